vga_pixel_fetch: RTL

Downstream of the HV sync generator: consumes its pixel tick, x/y counters, enable and raw sync flags, fetches the matching pixel from a double-buffered, low-resolution framebuffer RAM, and converts it to 24-bit RGB for the VGA DAC. It pipelines the sync and blank signals by the same depth as the memory path, so colour and sync stay aligned at the connector. A buffer-select input is latched once per frame, which gives tear-free page flipping.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_pixel_fetch_if.sv | 13 +
 rtl/vga_palette.sv | 24 ++
 rtl/vga_pixel_fetch.sv | 134 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing, framebuffer defaults, RGB type and RGB332 expansion.
package vga_pkg;

  localparam int unsigned HVisible = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned HTotal   = 800;
  localparam int unsigned VVisible = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 33;
  localparam int unsigned VTotal   = 525;

  localparam int unsigned FbWDefault       = 160;
  localparam int unsigned FbHDefault       = 120;
  localparam int unsigned ScaleLog2Default = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit replication so that full-scale codes map to 0xFF.
  function automatic rgb_t rgb332_to_rgb(input logic [7:0] p);
    rgb_t c;
    c.r = {p[7:5], p[7:5], p[7:6]};
    c.g = {p[4:2], p[4:2], p[4:3]};
    c.b = {4{p[1:0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read bus between the pixel fetcher (master) and the synchronous RAM (slave).
interface vga_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 16
);

  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd;
  logic [7:0]        fb_rdata;

  modport master (output fb_addr, output fb_rd, input fb_rdata);
  modport slave  (input fb_addr, input fb_rd, output fb_rdata);

endinterface

// File: rtl/vga_palette.sv
// 256x24 colour palette: one synchronous write port, one combinational read port, no reset.
module vga_palette
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] widx_i,
  input  rgb_t       wdata_i,
  input  logic [7:0] ridx_i,
  output rgb_t       rdata_o
);

  rgb_t mem_q [256];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  // A read in the same cycle as a write to that index still sees the old entry.
  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel fetch and colour conversion with sync/blank kept aligned to the memory path.
// Define PALETTE_EN to route pixels through a 256-entry palette instead of RGB332 expansion.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned FB_W       = FbWDefault,
  parameter int unsigned FB_H       = FbHDefault,
  parameter int unsigned SCALE_LOG2 = ScaleLog2Default,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_tick,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     enable,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     buf_sel,
  vga_pixel_fetch_if.master        fb,
  input  logic                     pal_we,
  input  logic [7:0]               pal_idx,
  input  logic [23:0]              pal_rgb,
  output logic [7:0]               vga_r,
  output logic [7:0]               vga_g,
  output logic [7:0]               vga_b,
  output logic                     vga_hsync_n,
  output logic                     vga_vsync_n,
  output logic                     vga_blank_n,
  output logic                     vga_sync_n,
  output logic                     vga_clk,
  output logic                     frame_start,
  output logic                     active_buf
);

  localparam int unsigned PixW     = ADDR_W - 1;
  localparam int unsigned FbPixels = FB_W * FB_H;
  localparam int unsigned RowW     = $clog2(FbPixels);

  logic [RowW-1:0]   row_base_q, row_base_d;
  logic [PixW-1:0]   pix_off;
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_rd_q;
  logic              active_buf_q, active_buf_d;
  logic              vsync_rise;
  logic              frame_start_q;
  logic              en_d1, hs_d1, vs_d1;
  logic              en_d2, hs_d2, vs_d2;
  rgb_t              pix_rgb;
  rgb_t              rgb_q;

  // Row base steps by one framebuffer line every 2^SCALE_LOG2 screen lines, avoiding a multiply.
  always_comb begin
    row_base_d = row_base_q;
    if (x == '0) begin
      if (y == '0) begin
        row_base_d = '0;
      end else if (y[SCALE_LOG2-1:0] == '0) begin
        row_base_d = row_base_q + RowW'(FB_W);
      end
    end
  end

  assign pix_off = PixW'(row_base_d) + PixW'(x >> SCALE_LOG2);

  // vs_d1 doubles as the previous sampled vsync for edge detection.
  assign vsync_rise   = pix_tick & vsync & ~vs_d1;
  assign active_buf_d = vsync_rise ? buf_sel : active_buf_q;

`ifdef PALETTE_EN
  rgb_t pal_rdata;

  vga_palette u_palette (
    .clk     (clk),
    .we_i    (pal_we),
    .widx_i  (pal_idx),
    .wdata_i (pal_rgb),
    .ridx_i  (fb.fb_rdata),
    .rdata_o (pal_rdata)
  );

  assign pix_rgb = pal_rdata;
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_idx, pal_rgb};
  assign pix_rgb    = rgb332_to_rgb(fb.fb_rdata);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_base_q    <= '0;
      fb_addr_q     <= '0;
      fb_rd_q       <= 1'b0;
      active_buf_q  <= 1'b0;
      frame_start_q <= 1'b0;
      en_d1         <= 1'b0;
      hs_d1         <= 1'b0;
      vs_d1         <= 1'b0;
      en_d2         <= 1'b0;
      hs_d2         <= 1'b0;
      vs_d2         <= 1'b0;
      rgb_q         <= '0;
    end else begin
      frame_start_q <= vsync_rise;
      if (pix_tick) begin
        row_base_q   <= row_base_d;
        active_buf_q <= active_buf_d;
        fb_addr_q    <= {active_buf_d, pix_off};
        fb_rd_q      <= enable;
        en_d1        <= enable;
        hs_d1        <= hsync;
        vs_d1        <= vsync;
        rgb_q        <= en_d1 ? pix_rgb : '0;
        en_d2        <= en_d1;
        hs_d2        <= hs_d1;
        vs_d2        <= vs_d1;
      end
    end
  end

  assign fb.fb_addr  = fb_addr_q;
  assign fb.fb_rd    = fb_rd_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hsync_n = ~hs_d2;
  assign vga_vsync_n = ~vs_d2;
  assign vga_blank_n = en_d2;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = pix_tick;
  assign frame_start = frame_start_q;
  assign active_buf  = active_buf_q;

endmodule
